// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: FSM states, requester IDs and default sizes.
// Optional round-robin arbitration is selected elsewhere by DATA_MEM_ARB_RR_EN.
package data_mem_arbiter_pkg;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_H = 1'b1
  } port_t;

endpackage

// File: rtl/data_mem_arbiter_ram16x4.sv
// Register-file storage for the arbitrated data RAM: sync write, async read,
// async clear on reset, plus a second read port feeding the debug mirror.
module data_mem_arbiter_ram16x4
  import data_mem_arbiter_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0][DW-1:0] mem;

  // One flop word per address so the whole array clears with reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DW-1:0] word_q;
      logic [DW-1:0] word_d;

      always_comb begin
        word_d = word_q;
        if (we && (addr == AW'(gi))) word_d = wdata;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) word_q <= '0;
        else       word_q <= word_d;
      end

      assign mem[gi] = word_q;
    end
  endgenerate

  assign rdata     = mem[addr];
  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the shared data RAM between CPU (C) and host (H): IDLE->BUSY->DONE per op.
// Define DATA_MEM_ARB_RR_EN for round-robin; default is CPU priority with host starvation guard.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = 3,
  parameter int DBG_ADDR     = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_ack,
  output logic [DW-1:0] h_rdata,
  output logic          busy,
  output logic [DW-1:0] dbg_data
);

  state_t        state_q, state_d;
  port_t         win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          c_gnt_q, c_gnt_d, h_gnt_q, h_gnt_d;
  logic          c_ack_q, c_ack_d, h_ack_q, h_ack_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d, h_rdata_q, h_rdata_d;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic          h_wins;

`ifdef DATA_MEM_ARB_RR_EN
  port_t last_q, last_d;

  // On contention the port that was not served last wins.
  assign h_wins = h_req && (!c_req || (last_q == PORT_C));
`else
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;

  assign h_wins = h_req && (!c_req || (starve_q == STARVE_MAX));
`endif

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_gnt_d   = 1'b0;
    h_gnt_d   = 1'b0;
    c_ack_d   = 1'b0;
    h_ack_d   = 1'b0;
    c_rdata_d = c_rdata_q;
    h_rdata_d = h_rdata_q;
    ram_we    = 1'b0;
`ifdef DATA_MEM_ARB_RR_EN
    last_d    = last_q;
`else
    starve_d  = starve_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (c_req || h_req) begin
          win_d   = h_wins ? PORT_H : PORT_C;
          we_d    = h_wins ? h_we : c_we;
          addr_d  = h_wins ? h_addr : c_addr;
          wdata_d = h_wins ? h_wdata : c_wdata;
          c_gnt_d = !h_wins;
          h_gnt_d = h_wins;
          state_d = ST_BUSY;
`ifdef DATA_MEM_ARB_RR_EN
          last_d  = h_wins ? PORT_H : PORT_C;
`else
          if (h_wins || !h_req)         starve_d = '0;
          else if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
`endif
        end
      end
      ST_BUSY: begin
        ram_we = we_q;
        if (!we_q) begin
          if (win_q == PORT_H) h_rdata_d = ram_rdata;
          else                 c_rdata_d = ram_rdata;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        c_ack_d = (win_q == PORT_C);
        h_ack_d = (win_q == PORT_H);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      win_q     <= PORT_C;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_gnt_q   <= 1'b0;
      h_gnt_q   <= 1'b0;
      c_ack_q   <= 1'b0;
      h_ack_q   <= 1'b0;
      c_rdata_q <= '0;
      h_rdata_q <= '0;
`ifdef DATA_MEM_ARB_RR_EN
      last_q    <= PORT_H;
`else
      starve_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_gnt_q   <= c_gnt_d;
      h_gnt_q   <= h_gnt_d;
      c_ack_q   <= c_ack_d;
      h_ack_q   <= h_ack_d;
      c_rdata_q <= c_rdata_d;
      h_rdata_q <= h_rdata_d;
`ifdef DATA_MEM_ARB_RR_EN
      last_q    <= last_d;
`else
      starve_q  <= starve_d;
`endif
    end
  end

  data_mem_arbiter_ram16x4 #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk      (clk),
    .reset    (reset),
    .we       (ram_we),
    .addr     (addr_q),
    .wdata    (wdata_q),
    .rdata    (ram_rdata),
    .dbg_addr (AW'(DBG_ADDR)),
    .dbg_rdata(dbg_data)
  );

  assign c_gnt   = c_gnt_q;
  assign h_gnt   = h_gnt_q;
  assign c_ack   = c_ack_q;
  assign h_ack   = h_ack_q;
  assign c_rdata = c_rdata_q;
  assign h_rdata = h_rdata_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus pushes expected grants/acks,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       c_req, c_we, h_req, h_we;
  logic [3:0] c_addr, c_wdata, h_addr, h_wdata;
  logic       c_gnt, c_ack, h_gnt, h_ack, busy;
  logic [3:0] c_rdata, h_rdata, dbg_data;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_ack(c_ack), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_ack(h_ack), .h_rdata(h_rdata),
    .busy(busy), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rd;
    logic [3:0] rdata;
    bit         chk_dbg;
    logic [3:0] dbg;
  } ack_t;

  port_t gnt_exp[$];
  ack_t  c_exp[$];
  ack_t  h_exp[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int c_ack_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or an ack.
  initial begin
    port_t p;
    ack_t  a;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (c_gnt && h_gnt) check("dual_grant", 8'd1, 8'd0);
        if (c_gnt || h_gnt) begin
          if (gnt_exp.size() == 0) check("unexpected_grant", {7'd0, h_gnt}, 8'hff);
          else begin
            p = gnt_exp.pop_front();
            check("grant_port", {7'd0, h_gnt}, {7'd0, p});
          end
        end
        if (c_ack) begin
          c_ack_cnt++;
          if (c_exp.size() == 0) check("unexpected_c_ack", 8'd1, 8'd0);
          else begin
            a = c_exp.pop_front();
            if (a.rd)      check("c_rdata", {4'd0, c_rdata}, {4'd0, a.rdata});
            if (a.chk_dbg) check("c_dbg_data", {4'd0, dbg_data}, {4'd0, a.dbg});
          end
        end
        if (h_ack) begin
          if (h_exp.size() == 0) check("unexpected_h_ack", 8'd1, 8'd0);
          else begin
            a = h_exp.pop_front();
            if (a.rd)      check("h_rdata", {4'd0, h_rdata}, {4'd0, a.rdata});
            if (a.chk_dbg) check("h_dbg_data", {4'd0, dbg_data}, {4'd0, a.dbg});
          end
        end
      end
    end
  end

  task automatic push_ack(input port_t p, input bit rd, input logic [3:0] rdata,
                          input bit chk_dbg, input logic [3:0] dbg);
    ack_t a;
    a.rd = rd; a.rdata = rdata; a.chk_dbg = chk_dbg; a.dbg = dbg;
    if (p == PORT_C) c_exp.push_back(a);
    else             h_exp.push_back(a);
  endtask

  // One complete access; with chk_lat the req->gnt->ack timing is also checked.
  task automatic do_op(input port_t p, input logic we, input logic [3:0] a,
                       input logic [3:0] d, input bit chk_lat);
    int  req_cyc, gnt_cyc, ack_cyc;
    bit  seen;
    @(posedge clk); #1;
    if (p == PORT_C) begin c_we = we; c_addr = a; c_wdata = d; c_req = 1'b1; end
    else             begin h_we = we; h_addr = a; h_wdata = d; h_req = 1'b1; end
    req_cyc = cyc;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = (p == PORT_C) ? c_gnt : h_gnt;
    end
    gnt_cyc = cyc;
    if (p == PORT_C) c_req = 1'b0; else h_req = 1'b0;
    if (!seen) begin
      check("gnt_timeout", 8'd0, 8'd1);
      return;
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (p == PORT_C) ? c_ack : h_ack;
    end
    ack_cyc = cyc;
    if (!seen) begin
      check("ack_timeout", 8'd0, 8'd1);
      return;
    end
    if (chk_lat) begin
      check("gnt_to_ack_cycles", 8'(ack_cyc - gnt_cyc), 8'd2);
      check("req_to_ack_cycles", 8'(ack_cyc - req_cyc), 8'd3);
    end
  endtask

  initial begin
    int ngnt, acks_before;
    bit seen;
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // 1: reset state
    check("rst_c_gnt", {7'd0, c_gnt}, 8'd0);
    check("rst_h_gnt", {7'd0, h_gnt}, 8'd0);
    check("rst_c_ack", {7'd0, c_ack}, 8'd0);
    check("rst_h_ack", {7'd0, h_ack}, 8'd0);
    check("rst_c_rdata", {4'd0, c_rdata}, 8'd0);
    check("rst_h_rdata", {4'd0, h_rdata}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_dbg_data", {4'd0, dbg_data}, 8'd0);

    // 2: C write addr3=5, debug mirror follows
    gnt_exp.push_back(PORT_C);
    push_ack(PORT_C, 0, 4'd0, 1, 4'd5);
    do_op(PORT_C, 1'b1, 4'd3, 4'd5, 1);

    // 3: H read addr3 sees the CPU write
    gnt_exp.push_back(PORT_H);
    push_ack(PORT_H, 1, 4'd5, 1, 4'd5);
    do_op(PORT_H, 1'b0, 4'd3, 4'd0, 1);

    // 4: continuous contention; C reads addr3 (5), H reads addr4 (0)
`ifdef DATA_MEM_ARB_RR_EN
    for (int i = 0; i < 8; i++) begin
      gnt_exp.push_back((i % 2 == 0) ? PORT_C : PORT_H);
      push_ack((i % 2 == 0) ? PORT_C : PORT_H, 1, (i % 2 == 0) ? 4'd5 : 4'd0, 0, 4'd0);
    end
`else
    for (int i = 0; i < 8; i++) begin
      gnt_exp.push_back((i % 4 == 3) ? PORT_H : PORT_C);
      push_ack((i % 4 == 3) ? PORT_H : PORT_C, 1, (i % 4 == 3) ? 4'd0 : 4'd5, 0, 4'd0);
    end
`endif
    @(posedge clk); #1;
    c_we = 0; c_addr = 4'd3; h_we = 0; h_addr = 4'd4;
    c_req = 1; h_req = 1;
    ngnt = 0;
    for (int i = 0; i < 200 && ngnt < 8; i++) begin
      @(negedge clk);
      if (c_gnt || h_gnt) ngnt++;
    end
    c_req = 0; h_req = 0;
    check("contention_grants", 8'(ngnt), 8'd8);
    repeat (4) @(negedge clk);

    // 5: reset during BUSY of C write addr7=9 aborts it
    gnt_exp.push_back(PORT_C);
    @(posedge clk); #1;
    c_we = 1; c_addr = 4'd7; c_wdata = 4'd9; c_req = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = c_gnt;
    end
    check("abort_gnt_seen", {7'd0, seen}, 8'd1);
    acks_before = c_ack_cnt;
    reset = 1'b1; c_req = 0;
    #1;
    check("abort_busy_in_reset", {7'd0, busy}, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_c_ack", 8'(c_ack_cnt - acks_before), 8'd0);
    check("abort_dbg_cleared", {4'd0, dbg_data}, 8'd0);
    gnt_exp.push_back(PORT_C);
    push_ack(PORT_C, 1, 4'd0, 0, 4'd0);
    do_op(PORT_C, 1'b0, 4'd7, 4'd0, 1);

    // 6: C write a2=A, H read a2 requested while C op is in flight
    gnt_exp.push_back(PORT_C);
    gnt_exp.push_back(PORT_H);
    push_ack(PORT_C, 0, 4'd0, 0, 4'd0);
    push_ack(PORT_H, 1, 4'hA, 0, 4'd0);
    fork
      do_op(PORT_C, 1'b1, 4'd2, 4'hA, 1);
      begin
        @(posedge clk);
        do_op(PORT_H, 1'b0, 4'd2, 4'd0, 0);
      end
    join
    repeat (4) @(negedge clk);

    check("grants_left", 8'(gnt_exp.size()), 8'd0);
    check("c_acks_left", 8'(c_exp.size()), 8'd0);
    check("h_acks_left", 8'(h_exp.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
